cmd_sched: RTL and testbench

- Sequencer for the command-packet parser on the fifoc byte stream.
- Watches the FIFO fill level and starts the parser with an fs/fd handshake once a full packet is buffered.
- Samples the parser err flag, then issues a config-apply or reject pulse.
- Counts good and bad packets, and flushes the FIFO after repeated consecutive errors to resync on packet boundaries.

---
 rtl/cmd_sched.sv | 215 +++++++++++++++++++++
 tb/tb_cmd_sched.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_sched.sv
// Command-packet scheduler: starts the parser once a full packet sits in fifoc, then applies or rejects it.
// Optional parse watchdog and parse_rst output are enabled by defining CMD_SCHED_TIMEOUT_EN.
module cmd_sched #(
  parameter logic [11:0] MIN_LEN = 12'd4,
  parameter logic [11:0] MAX_LEN = 12'd32,
  parameter logic [3:0]  MAX_ERR = 4'd3,
  parameter logic [3:0]  GAP_CYC = 4'd2
`ifdef CMD_SCHED_TIMEOUT_EN
  ,parameter logic [15:0] TIMEOUT = 16'd1024
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [11:0] cfg_len,
  input  logic [11:0] fifoc_cnt,
  output logic [11:0] data_len,
  output logic        fs,
  input  logic        fd,
  input  logic        err,
  output logic        cfg_apply,
  output logic        cfg_reject,
  output logic        fifo_flush,
  output logic        len_bad,
  output logic        busy,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
`ifdef CMD_SCHED_TIMEOUT_EN
  ,output logic       parse_rst
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_PARSE, S_RELEASE, S_APPLY, S_REJECT, S_FLUSH, S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] data_len_q, data_len_d;
  logic        fs_q, fs_d;
  logic        err_q, err_d;
  logic        cfg_apply_q, cfg_apply_d;
  logic        cfg_reject_q, cfg_reject_d;
  logic        fifo_flush_q, fifo_flush_d;
  logic        len_bad_q, len_bad_d;
  logic        busy_q, busy_d;
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] bad_cnt_q, bad_cnt_d;
  logic [3:0]  consec_err_q, consec_err_d;
  logic [3:0]  gap_q, gap_d;
  logic        len_ok;
`ifdef CMD_SCHED_TIMEOUT_EN
  logic [15:0] wdog_q, wdog_d;
  logic        tmo_q, tmo_d;
  logic        parse_rst_q, parse_rst_d;
`endif

  assign len_ok = (cfg_len >= MIN_LEN) && (cfg_len <= MAX_LEN);

  // Every output flop is written on the edge where the FSM performs the matching action.
  always_comb begin
    state_d      = state_q;
    data_len_d   = data_len_q;
    fs_d         = fs_q;
    err_d        = err_q;
    cfg_apply_d  = 1'b0;
    cfg_reject_d = 1'b0;
    fifo_flush_d = 1'b0;
    len_bad_d    = 1'b0;
    good_cnt_d   = good_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    consec_err_d = consec_err_q;
    gap_d        = gap_q;
`ifdef CMD_SCHED_TIMEOUT_EN
    wdog_d       = wdog_q;
    tmo_d        = tmo_q;
    parse_rst_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (!len_ok) begin
          len_bad_d = 1'b1;
        end else if (fifoc_cnt >= cfg_len) begin
          state_d    = S_PARSE;
          data_len_d = cfg_len;
          fs_d       = 1'b1;
`ifdef CMD_SCHED_TIMEOUT_EN
          wdog_d     = 16'd0;
          tmo_d      = 1'b0;
`endif
        end
      end
      S_PARSE: begin
        if (fd) begin
          err_d   = err;
          fs_d    = 1'b0;
          state_d = S_RELEASE;
        end
`ifdef CMD_SCHED_TIMEOUT_EN
        else if (wdog_q + 16'd1 >= TIMEOUT) begin
          fs_d         = 1'b0;
          bad_cnt_d    = (bad_cnt_q == 16'hFFFF) ? bad_cnt_q : bad_cnt_q + 16'd1;
          consec_err_d = 4'd0;
          tmo_d        = 1'b1;
          state_d      = S_FLUSH;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
`endif
      end
      S_RELEASE: begin
        fs_d = 1'b0;
        if (!fd) state_d = err_q ? S_REJECT : S_APPLY;
      end
      S_APPLY: begin
        cfg_apply_d  = 1'b1;
        good_cnt_d   = (good_cnt_q == 16'hFFFF) ? good_cnt_q : good_cnt_q + 16'd1;
        consec_err_d = 4'd0;
        gap_d        = GAP_CYC;
        state_d      = S_GAP;
      end
      S_REJECT: begin
        cfg_reject_d = 1'b1;
        bad_cnt_d    = (bad_cnt_q == 16'hFFFF) ? bad_cnt_q : bad_cnt_q + 16'd1;
        consec_err_d = consec_err_q + 4'd1;
        if (consec_err_q + 4'd1 == MAX_ERR) begin
          state_d = S_FLUSH;
        end else begin
          gap_d   = GAP_CYC;
          state_d = S_GAP;
        end
      end
      S_FLUSH: begin
        fifo_flush_d = 1'b1;
        consec_err_d = 4'd0;
`ifdef CMD_SCHED_TIMEOUT_EN
        parse_rst_d  = tmo_q;
        tmo_d        = 1'b0;
`endif
        gap_d        = GAP_CYC;
        state_d      = S_GAP;
      end
      S_GAP: begin
        // A zero gap setting still spends one cycle here.
        if (gap_q <= 4'd1) state_d = S_WAIT;
        else               gap_d   = gap_q - 4'd1;
      end
      default: begin
        state_d = S_IDLE;
        fs_d    = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      data_len_q   <= 12'd0;
      fs_q         <= 1'b0;
      err_q        <= 1'b0;
      cfg_apply_q  <= 1'b0;
      cfg_reject_q <= 1'b0;
      fifo_flush_q <= 1'b0;
      len_bad_q    <= 1'b0;
      busy_q       <= 1'b0;
      good_cnt_q   <= 16'd0;
      bad_cnt_q    <= 16'd0;
      consec_err_q <= 4'd0;
      gap_q        <= 4'd0;
`ifdef CMD_SCHED_TIMEOUT_EN
      wdog_q       <= 16'd0;
      tmo_q        <= 1'b0;
      parse_rst_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      data_len_q   <= data_len_d;
      fs_q         <= fs_d;
      err_q        <= err_d;
      cfg_apply_q  <= cfg_apply_d;
      cfg_reject_q <= cfg_reject_d;
      fifo_flush_q <= fifo_flush_d;
      len_bad_q    <= len_bad_d;
      busy_q       <= busy_d;
      good_cnt_q   <= good_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      consec_err_q <= consec_err_d;
      gap_q        <= gap_d;
`ifdef CMD_SCHED_TIMEOUT_EN
      wdog_q       <= wdog_d;
      tmo_q        <= tmo_d;
      parse_rst_q  <= parse_rst_d;
`endif
    end
  end

  assign data_len   = data_len_q;
  assign fs         = fs_q;
  assign cfg_apply  = cfg_apply_q;
  assign cfg_reject = cfg_reject_q;
  assign fifo_flush = fifo_flush_q;
  assign len_bad    = len_bad_q;
  assign busy       = busy_q;
  assign good_cnt   = good_cnt_q;
  assign bad_cnt    = bad_cnt_q;
`ifdef CMD_SCHED_TIMEOUT_EN
  assign parse_rst  = parse_rst_q;
`endif

endmodule

// File: tb/tb_cmd_sched.sv
// Directed bench for cmd_sched (default build): handshake timing, reject/flush, length limits, enable drop, reset.
module tb_cmd_sched;

  logic        clk = 1'b0;
  logic        rst, enable, fd, err;
  logic [11:0] cfg_len, fifoc_cnt, data_len;
  logic        fs, cfg_apply, cfg_reject, fifo_flush, len_bad, busy;
  logic [15:0] good_cnt, bad_cnt;

  int checks = 0;
  int errors = 0;
  int applyPulses = 0;
  int rejectPulses = 0;
  int flushPulses = 0;
  int exclViolations = 0;

  cmd_sched dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_len(cfg_len), .fifoc_cnt(fifoc_cnt),
    .data_len(data_len), .fs(fs), .fd(fd), .err(err),
    .cfg_apply(cfg_apply), .cfg_reject(cfg_reject), .fifo_flush(fifo_flush),
    .len_bad(len_bad), .busy(busy), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  always #5 clk = ~clk;

  // Tally each pulse once per cycle and note any cycle with more than one asserted.
  always @(negedge clk) begin
    if (cfg_apply)  applyPulses++;
    if (cfg_reject) rejectPulses++;
    if (fifo_flush) flushPulses++;
    if ((32'(cfg_apply) + 32'(cfg_reject) + 32'(fifo_flush)) > 1) exclViolations++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic en, input logic [11:0] len,
                               input logic [11:0] cnt, input logic d, input logic e);
    rst = r; enable = en; cfg_len = len; fifoc_cnt = cnt; fd = d; err = e;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Waits (bounded) for fs, then plays a parser that finishes with the given err bit.
  // Returns on the cycle where the apply/reject pulse is visible.
  task automatic doPacket(input logic errBit);
    int waitCycles;
    waitCycles = 0;
    while (!fs && waitCycles < 20) begin
      tick();
      waitCycles++;
    end
    checkOutput("pkt_fs_rise", {15'd0, fs}, 16'd1);
    fd = 1'b1; err = errBit;
    tick();
    checkOutput("pkt_fs_drop", {15'd0, fs}, 16'd0);
    fd = 1'b0; err = 1'b0;
    tick();
    tick();
    checkOutput("pkt_apply", {15'd0, cfg_apply}, {15'd0, ~errBit});
    checkOutput("pkt_reject", {15'd0, cfg_reject}, {15'd0, errBit});
  endtask

  initial begin
    $display("[TB] cmd_sched directed test starting");

    // Reset state
    applyStimulus(1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0);
    tick(); tick();
    applyStimulus(1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0);
    checkOutput("rst_fs", {15'd0, fs}, 16'd0);
    checkOutput("rst_busy", {15'd0, busy}, 16'd0);
    checkOutput("rst_good", good_cnt, 16'd0);
    checkOutput("rst_bad", bad_cnt, 16'd0);
    checkOutput("rst_data_len", {4'd0, data_len}, 16'd0);

    // Basic good packet, fifo ramping up to exactly cfg_len
    applyStimulus(1'b0, 1'b1, 12'd12, 12'd0, 1'b0, 1'b0);
    tick();
    fifoc_cnt = 12'd4;  tick();
    fifoc_cnt = 12'd8;  tick();
    checkOutput("ramp_fs_low", {15'd0, fs}, 16'd0);
    fifoc_cnt = 12'd12; tick();
    checkOutput("ramp_fs_high", {15'd0, fs}, 16'd1);
    checkOutput("ramp_data_len", {4'd0, data_len}, 16'd12);
    checkOutput("ramp_busy", {15'd0, busy}, 16'd1);
    cfg_len = 12'd20;
    tick();
    checkOutput("hold_fs", {15'd0, fs}, 16'd1);
    fd = 1'b1; err = 1'b0; tick();
    checkOutput("fd_fs_drop", {15'd0, fs}, 16'd0);
    checkOutput("len_ignored", {4'd0, data_len}, 16'd12);
    tick();
    checkOutput("release_wait", {15'd0, cfg_apply}, 16'd0);
    fd = 1'b0; tick();
    checkOutput("apply_not_yet", {15'd0, cfg_apply}, 16'd0);
    tick();
    checkOutput("apply_pulse", {15'd0, cfg_apply}, 16'd1);
    checkOutput("apply_good", good_cnt, 16'd1);
    checkOutput("apply_busy", {15'd0, busy}, 16'd1);
    tick();
    checkOutput("apply_one_cycle", {15'd0, cfg_apply}, 16'd0);
    tick();
    checkOutput("gap_done_busy", {15'd0, busy}, 16'd0);
    checkOutput("data_len_stable", {4'd0, data_len}, 16'd12);

    // Three consecutive rejects cause a flush
    cfg_len = 12'd8; fifoc_cnt = 12'd8;
    doPacket(1'b1);
    checkOutput("rej1_bad", bad_cnt, 16'd1);
    doPacket(1'b1);
    checkOutput("rej2_bad", bad_cnt, 16'd2);
    doPacket(1'b1);
    checkOutput("rej3_bad", bad_cnt, 16'd3);
    checkOutput("rej3_no_flush_yet", {15'd0, fifo_flush}, 16'd0);
    tick();
    checkOutput("flush_pulse", {15'd0, fifo_flush}, 16'd1);
    checkOutput("flush_reject_low", {15'd0, cfg_reject}, 16'd0);
    tick();
    checkOutput("flush_one_cycle", {15'd0, fifo_flush}, 16'd0);
    doPacket(1'b0);
    checkOutput("after_flush_good", good_cnt, 16'd2);

    // A good packet clears the error run: err, err, ok, err must not flush
    doPacket(1'b1);
    doPacket(1'b1);
    doPacket(1'b0);
    checkOutput("run_good", good_cnt, 16'd3);
    doPacket(1'b1);
    checkOutput("run_bad", bad_cnt, 16'd6);
    tick();
    checkOutput("run_no_flush", {15'd0, fifo_flush}, 16'd0);

    // Out-of-range lengths with plenty of data
    cfg_len = 12'd3; fifoc_cnt = 12'd100;
    tick(); tick(); tick();
    checkOutput("len3_bad", {15'd0, len_bad}, 16'd1);
    checkOutput("len3_fs", {15'd0, fs}, 16'd0);
    cfg_len = 12'd40;
    tick(); tick();
    checkOutput("len40_bad", {15'd0, len_bad}, 16'd1);
    checkOutput("len40_fs", {15'd0, fs}, 16'd0);
    checkOutput("len_bad_counts", bad_cnt, 16'd6);

    // MIN_LEN boundary, one byte short then exact; enable dropped mid-transaction
    cfg_len = 12'd4; fifoc_cnt = 12'd3;
    tick();
    checkOutput("min_len_ok", {15'd0, len_bad}, 16'd0);
    tick();
    checkOutput("short_no_fs", {15'd0, fs}, 16'd0);
    fifoc_cnt = 12'd4;
    tick();
    checkOutput("min_len_fs", {15'd0, fs}, 16'd1);
    checkOutput("min_len_data_len", {4'd0, data_len}, 16'd4);
    enable = 1'b0;
    doPacket(1'b0);
    checkOutput("en_drop_good", good_cnt, 16'd4);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("en_drop_idle_fs", {15'd0, fs}, 16'd0);
    checkOutput("en_drop_idle_busy", {15'd0, busy}, 16'd0);

    // MAX_LEN boundary with fd already high on the first PARSE cycle
    applyStimulus(1'b0, 1'b1, 12'd32, 12'd100, 1'b1, 1'b0);
    tick();
    checkOutput("max_wait_fs", {15'd0, fs}, 16'd0);
    tick();
    checkOutput("max_fs", {15'd0, fs}, 16'd1);
    checkOutput("max_data_len", {4'd0, data_len}, 16'd32);
    tick();
    checkOutput("early_fd_fs_drop", {15'd0, fs}, 16'd0);
    fd = 1'b0;
    tick(); tick();
    checkOutput("early_fd_apply", {15'd0, cfg_apply}, 16'd1);
    checkOutput("early_fd_good", good_cnt, 16'd5);

    // Reset while the parser is busy
    cfg_len = 12'd8; fifoc_cnt = 12'd8;
    for (int i = 0; i < 20 && !fs; i++) tick();
    checkOutput("pre_rst_fs", {15'd0, fs}, 16'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_rst_fs", {15'd0, fs}, 16'd0);
    checkOutput("mid_rst_good", good_cnt, 16'd0);
    checkOutput("mid_rst_bad", bad_cnt, 16'd0);
    checkOutput("mid_rst_busy", {15'd0, busy}, 16'd0);
    checkOutput("mid_rst_data_len", {4'd0, data_len}, 16'd0);
    tick();
    checkOutput("post_rst_idle_fs", {15'd0, fs}, 16'd0);
    tick();
    checkOutput("post_rst_restart_fs", {15'd0, fs}, 16'd1);

    // Whole-run pulse totals and exclusivity
    @(negedge clk);
    checkOutput("total_apply", 16'(applyPulses), 16'd5);
    checkOutput("total_reject", 16'(rejectPulses), 16'd6);
    checkOutput("total_flush", 16'(flushPulses), 16'd1);
    checkOutput("pulse_exclusive", 16'(exclViolations), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
